// File: rtl/sqrt_pkg.sv
// Shared widths and FSM state type for the square-root unit and its squaring self-check.
package sqrt_pkg;

    localparam int unsigned ROOT_W = 8;
    localparam int unsigned RAD_W  = 2 * ROOT_W;
    localparam int unsigned REM_W  = RAD_W + 1;
    localparam int unsigned CNT_W  = $clog2(ROOT_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator: flags A strictly less than B.
module comparator #(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0] A_i,
    input  logic [W-1:0] B_i,
    output logic         A_less_than_B_o
);

    assign A_less_than_B_o = (A_i < B_i);

endmodule

// File: rtl/square_check.sv
// Shift-add squarer that validates a candidate integer square root against its radicand.
module square_check
    import sqrt_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ROOT_W-1:0] root_i,
    input  logic [RAD_W-1:0]  radicand_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [RAD_W-1:0]  square_o,
    output logic [REM_W-1:0]  remainder_o,
    output logic              root_ok_o
);

    state_e              state_q,  state_d;
    logic [RAD_W-1:0]    mcand_q,  mcand_d;
    logic [ROOT_W-1:0]   mplier_q, mplier_d;
    logic [ROOT_W-1:0]   root_q,   root_d;
    logic [RAD_W-1:0]    rad_q,    rad_d;
    logic [RAD_W-1:0]    acc_q,    acc_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [RAD_W-1:0]    square_q, square_d;
    logic [REM_W-1:0]    rem_q,    rem_d;
    logic                ok_q,     ok_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    logic [REM_W-1:0]    rem_c;
    logic [REM_W-1:0]    twice_root_c;
    logic                reject_c;

    // Borrow lands in the MSB when the root overshoots the radicand.
    assign rem_c        = REM_W'({1'b0, rad_q}) - REM_W'({1'b0, acc_q});
    assign twice_root_c = REM_W'({root_q, 1'b0});

    // Upper-bound test: radicand < (root+1)^2  <=>  remainder <= 2*root.
    comparator #(
        .W (REM_W)
    ) u_bound_cmp (
        .A_i             (twice_root_c),
        .B_i             (rem_c),
        .A_less_than_B_o (reject_c)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            root_q   <= '0;
            rad_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            square_q <= '0;
            rem_q    <= '0;
            ok_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            root_q   <= root_d;
            rad_q    <= rad_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            square_q <= square_d;
            rem_q    <= rem_d;
            ok_q     <= ok_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        root_d   = root_q;
        rad_d    = rad_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        square_d = square_q;
        rem_d    = rem_q;
        ok_d     = ok_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d  = RAD_W'(root_i);
                    mplier_d = root_i;
                    root_d   = root_i;
                    rad_d    = radicand_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MULT;
                end
            end
            MULT: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ROOT_W - 1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                square_d = acc_q;
                rem_d    = rem_c;
                ok_d     = ~rem_c[REM_W-1] & ~reject_c;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered copies of the upcoming state.
        busy_d = (state_d == MULT) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign square_o    = square_q;
    assign remainder_o = rem_q;
    assign root_ok_o   = ok_q;

endmodule

// File: tb/tb_square_check.sv
// Directed-vector bench for the square_check root validation stage.
module tb_square_check;
    import sqrt_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ROOT_W-1:0] root;
    logic [RAD_W-1:0]  rad;
    logic              busy;
    logic              done;
    logic [RAD_W-1:0]  square;
    logic [REM_W-1:0]  remainder;
    logic              root_ok;

    int n_checks = 0;
    int n_fail   = 0;

    square_check dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .root_i      (root),
        .radicand_i  (rad),
        .busy_o      (busy),
        .done_o      (done),
        .square_o    (square),
        .remainder_o (remainder),
        .root_ok_o   (root_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  root;
        logic [15:0] rad;
        logic [15:0] sq;
        logic [16:0] rem;
        logic        ok;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation, wait for done and return its latency in cycles after acceptance.
    task automatic run_op(input logic [7:0] r, input logic [15:0] d, output int lat);
        @(negedge clk);
        root  = r;
        rad   = d;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int lat;
        int pulses;
        int viol;
        int cyc;
        int t[3];
        logic [15:0] sq_seen;
        logic [16:0] rem_seen;
        logic        ok_seen;

        vecs[0] = '{8'hFF, 16'hFFFF, 16'hFE01, 17'h001FE, 1'b1};
        vecs[1] = '{8'd0,  16'd0,    16'd0,    17'd0,     1'b1};
        vecs[2] = '{8'd16, 16'd300,  16'd256,  17'd44,    1'b0};
        vecs[3] = '{8'd20, 16'd399,  16'd400,  17'h1FFFF, 1'b0};
        vecs[4] = '{8'd3,  16'd10,   16'd9,    17'd1,     1'b1};
        vecs[5] = '{8'd15, 16'd255,  16'd225,  17'd30,    1'b1};
        vecs[6] = '{8'd1,  16'd4,    16'd1,    17'd3,     1'b0};
        vecs[7] = '{8'd0,  16'd1,    16'd0,    17'd1,     1'b0};
        vecs[8] = '{8'd16, 16'd256,  16'd256,  17'd0,     1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        root  = '0;
        rad   = '0;
        #23;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_square", 32'(square), 32'd0);
        chk("reset_rem", 32'(remainder), 32'd0);
        chk("reset_ok", 32'(root_ok), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].root, vecs[i].rad, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd9);
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_square", i), 32'(square), 32'(vecs[i].sq));
            chk($sformatf("v%0d_rem", i), 32'(remainder), 32'(vecs[i].rem));
            chk($sformatf("v%0d_ok", i), 32'(root_ok), 32'(vecs[i].ok));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_square_hold", i), 32'(square), 32'(vecs[i].sq));
        end

        // Reset four cycles into an operation clears everything at once.
        @(negedge clk);
        root  = 8'd200;
        rad   = 16'd40000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_square", 32'(square), 32'd0);
        chk("midrst_rem", 32'(remainder), 32'd0);
        chk("midrst_ok", 32'(root_ok), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("midrst_no_done", 32'(pulses), 32'd0);
        run_op(8'd200, 16'd40000, lat);
        chk("restart_latency", 32'(lat), 32'd9);
        chk("restart_square", 32'(square), 32'd40000);
        chk("restart_rem", 32'(remainder), 32'd0);
        chk("restart_ok", 32'(root_ok), 32'd1);
        @(posedge clk);

        // start toggling during MULT must not disturb the captured operands.
        @(negedge clk);
        root  = 8'd3;
        rad   = 16'd10;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        root  = 8'd7;
        rad   = 16'd60000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start;
        end
        start    = 1'b0;
        pulses   = 0;
        sq_seen  = '0;
        rem_seen = '0;
        ok_seen  = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                sq_seen  = square;
                rem_seen = remainder;
                ok_seen  = root_ok;
            end
        end
        chk("busy_start_pulses", 32'(pulses), 32'd1);
        chk("busy_start_square", 32'(sq_seen), 32'd9);
        chk("busy_start_rem", 32'(rem_seen), 32'd1);
        chk("busy_start_ok", 32'(ok_seen), 32'd1);

        // start held high gives back-to-back operations.
        @(negedge clk);
        root   = 8'd5;
        rad    = 16'd30;
        start  = 1'b1;
        pulses = 0;
        viol   = 0;
        cyc    = 0;
        t      = '{0, 0, 0};
        while (cyc < 60 && pulses < 3) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy && done) viol++;
            if (done) begin
                t[pulses] = cyc;
                pulses++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("held_pulses", 32'(pulses), 32'd3);
        chk("held_spacing0", 32'(t[1] - t[0]), 32'd11);
        chk("held_spacing1", 32'(t[2] - t[1]), 32'd11);
        chk("held_busy_done_overlap", 32'(viol), 32'd0);
        chk("held_square", 32'(square), 32'd25);
        chk("held_rem", 32'(remainder), 32'd5);
        chk("held_ok", 32'(root_ok), 32'd1);
        repeat (15) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
